// File: rtl/sccb_config.sv
// OV7670 register loader: walks a fixed {reg, val} table and issues 3-phase SCCB writes
// on an open-drain data line, with a timed pause after the soft-reset entry.
module sccb_config #(
    parameter int unsigned QUARTER      = 63,
    parameter int unsigned DELAY_CYCLES = 25000,
    parameter logic [7:0]  DEV_ID       = 8'h42
) (
    input  logic clk_25,
    input  logic reset_n,
    input  logic start,
    output logic sio_c,
    inout  wire  sio_d,
    output logic busy,
    output logic done,
    output logic ack_err
);

    localparam int unsigned QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StStart, StBit, StAck, StStop, StDelay, StNext, StDone
    } state_e;

    state_e          r_state, w_state_next;
    logic [QW-1:0]   r_q;
    logic [1:0]      r_qi;
    logic [2:0]      r_bit;
    logic [1:0]      r_phase;
    logic [3:0]      r_idx;
    logic [DW-1:0]   r_dly;
    logic            r_done;
    logic            r_ack_err;

    logic [15:0]     w_entry;
    logic [7:0]      w_byte;
    logic            w_q_end;
    logic            w_dly_end;
    logic            w_start_ok;
    logic            w_on_bus;
    logic            w_sda_low;

    assign w_q_end    = (r_q == QW'(QUARTER - 1));
    assign w_dly_end  = (r_dly == DW'(DELAY_CYCLES - 1));
    assign w_start_ok = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_on_bus   = (r_state == StStart) || (r_state == StBit) ||
                        (r_state == StAck) || (r_state == StStop);

    // Anything past the end marker also reads as the end marker.
    always_comb begin
        case (r_idx)
            4'd0:    w_entry = 16'h1280;
            4'd1:    w_entry = 16'hFFF0;
            4'd2:    w_entry = 16'h1200;
            4'd3:    w_entry = 16'h0C04;
            4'd4:    w_entry = 16'h3E1A;
            4'd5:    w_entry = 16'h7222;
            4'd6:    w_entry = 16'h73F2;
            default: w_entry = 16'hFFFF;
        endcase
    end

    always_comb begin
        case (r_phase)
            2'd0:    w_byte = DEV_ID;
            2'd1:    w_byte = w_entry[15:8];
            default: w_byte = w_entry[7:0];
        endcase
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone: if (start) w_state_next = StNext;
            StNext: begin
                if (w_entry == 16'hFFFF)      w_state_next = StDone;
                else if (w_entry == 16'hFFF0) w_state_next = StDelay;
                else                          w_state_next = StStart;
            end
            StStart: if (w_q_end && r_qi == 2'd1) w_state_next = StBit;
            StBit:   if (w_q_end && r_qi == 2'd3 && r_bit == 3'd0) w_state_next = StAck;
            StAck: begin
                if (w_q_end && r_qi == 2'd3) w_state_next = (r_phase == 2'd2) ? StStop : StBit;
            end
            StStop:  if (w_q_end && r_qi == 2'd2) w_state_next = StNext;
            StDelay: if (w_dly_end) w_state_next = StNext;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            r_q       <= '0;
            r_qi      <= '0;
            r_bit     <= '0;
            r_phase   <= '0;
            r_idx     <= '0;
            r_dly     <= '0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            if (w_on_bus) r_q <= w_q_end ? '0 : r_q + 1'b1;
            else          r_q <= '0;

            // Quarter index wraps 3->0 on its own between consecutive bits.
            if (w_state_next != r_state)  r_qi <= '0;
            else if (w_on_bus && w_q_end) r_qi <= r_qi + 2'd1;

            if (r_state == StNext) r_bit <= 3'd7;
            else if (r_state == StBit && w_q_end && r_qi == 2'd3) r_bit <= r_bit - 3'd1;

            if (r_state == StNext) r_phase <= '0;
            else if (r_state == StAck && w_q_end && r_qi == 2'd3)
                r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;

            if (w_start_ok) r_idx <= '0;
            else if ((r_state == StStop && w_q_end && r_qi == 2'd2) ||
                     (r_state == StDelay && w_dly_end))
                r_idx <= r_idx + 4'd1;

            if (r_state == StDelay) r_dly <= w_dly_end ? '0 : r_dly + 1'b1;
            else                    r_dly <= '0;

            if (w_start_ok) r_done <= 1'b0;
            else if (r_state == StNext && w_entry == 16'hFFFF) r_done <= 1'b1;

            if (w_start_ok) r_ack_err <= 1'b0;
            else if (r_state == StAck && r_qi == 2'd1 && w_q_end && sio_d) r_ack_err <= 1'b1;
        end
    end

    always_comb begin
        sio_c     = 1'b1;
        w_sda_low = 1'b0;
        busy      = 1'b1;
        case (r_state)
            StIdle, StDone: busy = 1'b0;
            StStart: w_sda_low = (r_qi == 2'd1);
            StBit: begin
                sio_c     = (r_qi == 2'd1) || (r_qi == 2'd2);
                w_sda_low = ~w_byte[r_bit];
            end
            StAck: sio_c = (r_qi == 2'd1) || (r_qi == 2'd2);
            StStop: begin
                sio_c     = (r_qi != 2'd0);
                w_sda_low = (r_qi != 2'd2);
            end
            default: ;
        endcase
    end

    assign sio_d   = w_sda_low ? 1'b0 : 1'bz;
    assign done    = r_done;
    assign ack_err = r_ack_err;

endmodule

// File: tb/tb_sccb_config.sv
// Bench for sccb_config: an SCCB slave/decoder monitor checks the byte stream, bus
// timing and ack_err against a table-walk model through a scoreboard.
module tb_sccb_config;

    localparam int unsigned Q   = 4;
    localparam int unsigned D   = 20;
    localparam logic [7:0]  DEV = 8'h42;

    logic clk_25  = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic sio_c, busy, done, ack_err;
    wire  sio_d;
    logic slave_low = 1'b0;

    assign sio_d = slave_low ? 1'b0 : 1'bz;
    pullup (sio_d);

    sccb_config #(.QUARTER(Q), .DELAY_CYCLES(D), .DEV_ID(DEV)) u_dut (
        .clk_25  (clk_25),
        .reset_n (reset_n),
        .start   (start),
        .sio_c   (sio_c),
        .sio_d   (sio_d),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    always #5 clk_25 = ~clk_25;

    int unsigned cyc = 0;
    always @(posedge clk_25) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference table and scoreboard queues
    logic [15:0] rom_m [8] = '{16'h1280, 16'hFFF0, 16'h1200, 16'h0C04,
                               16'h3E1A, 16'h7222, 16'h73F2, 16'hFFFF};
    logic [7:0] exp_bytes [$];
    logic       exp_ae    [$];
    int         exp_gap   [$];
    bit         nack_pat  [18];
    logic       exp_final_ae;

    // Monitor / slave state
    logic        prev_c = 1'b1;
    logic        prev_d = 1'b1;
    bit          in_frame = 1'b0;
    int          bitcnt = 0;
    int          byte_n = 0;
    int          viol = 0;
    int unsigned t_start = 0;
    int unsigned t_stop = 0;
    logic [7:0]  shreg = '0;

    always @(negedge clk_25) begin
        logic c, d;
        int   g;
        c = sio_c;
        d = sio_d;
        if (!reset_n) begin
            in_frame  = 1'b0;
            bitcnt    = 0;
            slave_low = 1'b0;
            prev_c    = 1'b1;
            prev_d    = 1'b1;
        end else begin
            if (!in_frame && (c != prev_c)) viol++;
            if (prev_c && c && prev_d && !d) begin
                if (in_frame) viol++;
                in_frame = 1'b1;
                bitcnt   = 0;
                if (exp_gap.size() == 0) chk("unexpected_write", exp_gap.size(), 1);
                else begin
                    g = exp_gap.pop_front();
                    if (g >= 0) chk("start_gap", cyc - t_stop, g);
                end
                t_start = cyc;
            end else if (prev_c && c && !prev_d && d) begin
                if (!in_frame) viol++;
                else begin
                    chk("bits_per_write", bitcnt, 27);
                    chk("write_length", cyc - t_start, 111 * Q);
                end
                in_frame = 1'b0;
                t_stop   = cyc;
            end
            // Rising clock after the 27th bit is the stop clock, not data.
            if (in_frame && !prev_c && c && bitcnt < 27) begin
                if (bitcnt % 9 == 8) begin
                    if (exp_bytes.size() == 0) chk("extra_byte", exp_bytes.size(), 1);
                    else begin
                        chk("byte", shreg, exp_bytes.pop_front());
                        chk("ack_err_at_byte", ack_err, exp_ae.pop_front());
                    end
                    byte_n++;
                end else begin
                    shreg = {shreg[6:0], d};
                end
                bitcnt++;
            end
            if (in_frame && prev_c && !c)
                slave_low = (bitcnt % 9 == 8) && (byte_n < 18) && !nack_pat[byte_n];
            prev_c = c;
            prev_d = d;
        end
    end

    // mode 0: slave always ACKs, 1: never ACKs, 2: random per byte
    task automatic prep_run(input int mode);
        bit   after_delay, first, ended;
        logic acc;
        int   k;
        exp_bytes.delete();
        exp_ae.delete();
        exp_gap.delete();
        for (int i = 0; i < 18; i++)
            nack_pat[i] = (mode == 1) ? 1'b1 : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        byte_n = 0;
        viol = 0;
        acc = 1'b0;
        k = 0;
        after_delay = 1'b0;
        first = 1'b1;
        ended = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!ended) begin
                if (rom_m[i] == 16'hFFFF) ended = 1'b1;
                else if (rom_m[i] == 16'hFFF0) after_delay = 1'b1;
                else begin
                    exp_gap.push_back(first ? -1 : after_delay ? int'(2 * Q + D + 2)
                                                               : int'(2 * Q + 1));
                    exp_bytes.push_back(DEV);
                    exp_bytes.push_back(rom_m[i][15:8]);
                    exp_bytes.push_back(rom_m[i][7:0]);
                    for (int b = 0; b < 3; b++) begin
                        exp_ae.push_back(acc);
                        acc = acc | nack_pat[k];
                        k++;
                    end
                    first = 1'b0;
                    after_delay = 1'b0;
                end
            end
        end
        exp_final_ae = acc;
    endtask

    task automatic begin_run();
        repeat ($urandom_range(0, 7)) @(posedge clk_25);
        #1 start = 1'b1;
        @(posedge clk_25);
        #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("ack_err_cleared", ack_err, 0);
    endtask

    task automatic finish_run(input bit extra);
        int r1, r2;
        bit got;
        r1 = $urandom_range(10, 1200);
        r2 = $urandom_range(1300, 2500);
        got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(posedge clk_25);
            #1;
            start = extra && (i == r1 || i == r2);
            got = done;
        end
        start = 1'b0;
        chk("done_within_budget", got, 1);
        @(negedge clk_25);
        chk("done_final", done, 1);
        chk("busy_final", busy, 0);
        chk("ack_err_final", ack_err, exp_final_ae);
        chk("bytes_outstanding", exp_bytes.size(), 0);
        chk("writes_outstanding", exp_gap.size(), 0);
        chk("protocol_violations", viol, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_25);
        #1;
        chk("reset_sio_c", sio_c, 1);
        chk("reset_sio_d", sio_d, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ack_err", ack_err, 0);
        reset_n = 1'b1;
        repeat (6) @(posedge clk_25);
        #1;
        chk("idle_holds_busy", busy, 0);
        chk("idle_holds_sio_c", sio_c, 1);

        prep_run(0); begin_run(); finish_run(1'b0);
        prep_run(1); begin_run(); finish_run(1'b0);
        prep_run(2); begin_run(); finish_run(1'b1);
        prep_run(2); begin_run(); finish_run(1'b1);

        // Reset in the low half of bit 3 of the register phase
        prep_run(1);
        begin_run();
        for (int i = 0; i < 3000 && !(in_frame && bitcnt == 14); i++) @(posedge clk_25);
        chk("reached_reg_bit3", bitcnt, 14);
        for (int i = 0; i < 4 * Q && sio_c; i++) @(posedge clk_25);
        #2;
        chk("pre_reset_sio_c_low", sio_c, 0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_sio_c", sio_c, 1);
        chk("async_reset_sio_d", sio_d, 1);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ack_err", ack_err, 0);
        chk("async_reset_done", done, 0);
        repeat (3) @(posedge clk_25);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk_25);
        #1;
        chk("post_reset_idle_busy", busy, 0);
        chk("post_reset_idle_sio_c", sio_c, 1);

        prep_run(2); begin_run(); finish_run(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
